multimode_counter: RTL

Parametrised single-channel counter that unifies the team's binary, ring, state-machine and count-by-N counters behind one runtime-selectable mode input. It adds up/down, modulo-N with programmable step, Johnson and Gray sequences, synchronous load, a terminal-count flag and a registered wrap pulse. It drops in wherever a fixed-sequence counter is used today and is exercised by the same enable/reset style of bench.

---
 rtl/multimode_counter.sv | 117 +++++++++++
 1 files changed

// File: rtl/multimode_counter.sv
// Runtime-selectable counter: binary up/down, modulo-N by step, ring, Johnson, Gray.
// Mode changes reseed; load beats enable; wrap is registered from terminal.
module multimode_counter #(
    parameter int     WIDTH = 4,
    parameter longint MOD   = 16,
    parameter int     STEP  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [2:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic             terminal,
    output logic             wrap
);

    localparam logic [WIDTH:0]   MOD_W   = (WIDTH+1)'(MOD);
    localparam logic [WIDTH:0]   STEP_W  = (WIDTH+1)'(STEP);
    localparam logic [WIDTH-1:0] MSB_ONE = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic [WIDTH-1:0] count_q, count_d;
    logic [2:0]       mode_q, mode_d;
    logic             wrap_q, wrap_d;

    logic [WIDTH-1:0] nxt, seed, bin, binp;
    logic [WIDTH:0]   sum, diff;
    logic             term, reserved;

    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    always_comb begin
        bin      = gray2bin(count_q);
        binp     = bin + ONE;
        sum      = {1'b0, count_q} + STEP_W;
        diff     = sum - MOD_W;
        nxt      = count_q;
        seed     = '0;
        term     = 1'b0;
        reserved = 1'b0;
        case (mode)
            3'd0: begin
                nxt  = count_q + ONE;
                term = &count_q;
            end
            3'd1: begin
                nxt  = count_q - ONE;
                term = (count_q == '0);
            end
            3'd2: begin
                term = (sum >= MOD_W);
                nxt  = term ? diff[WIDTH-1:0] : sum[WIDTH-1:0];
            end
            3'd3: begin
                seed = ONE;
                nxt  = {count_q[WIDTH-2:0], count_q[WIDTH-1]};
                term = (count_q == MSB_ONE);
            end
            3'd4: begin
                nxt  = {count_q[WIDTH-2:0], ~count_q[WIDTH-1]};
                term = (count_q == MSB_ONE);
            end
            3'd5: begin
                nxt  = binp ^ (binp >> 1);
                term = &bin;
            end
            default: reserved = 1'b1;
        endcase
    end

    always_comb begin
        mode_d  = mode;
        count_d = count_q;
        wrap_d  = 1'b0;
        if (reserved) begin
            count_d = count_q;
        end else if (mode != mode_q) begin
            count_d = seed;
        end else if (load) begin
            // Out-of-range modulo loads collapse to the seed
            if (mode == 3'd2 && {1'b0, load_value} >= MOD_W) begin
                count_d = '0;
            end else begin
                count_d = load_value;
            end
        end else if (enable) begin
            count_d = nxt;
            wrap_d  = term;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
            mode_q  <= 3'd0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            mode_q  <= mode_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count    = count_q;
    assign terminal = term;
    assign wrap     = wrap_q;

endmodule
